// File: rtl/fft_bitrev_var_pkg.sv
// Shared types and helpers for the runtime-size bit-reversal reorder stage.
package fft_pkg;

   localparam int LGMINSIZE_DEF = 2;
   // Width of the generic reversal helper; frame sizes up to 2^16 are covered.
   localparam int BRW = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   // Reverse the low l bits of idx.  Bits at position l and above come out zero.
   function automatic logic [BRW-1:0] bitrev(input logic [BRW-1:0] idx, input logic [4:0] l);
      logic [BRW-1:0] rev;
      rev = {<<{idx}};
      return rev >> (BRW - int'(l));
   endfunction

endpackage

// File: rtl/fft_bitrev_var_if.sv
// Sample stream into and reordered stream out of the bit-reversal stage.
interface fft_bitrev_var_if #(
   parameter int LGMAXSIZE = 9,
   parameter int WIDTH     = 26,
   parameter int LGW       = $clog2(LGMAXSIZE + 1)
);
   logic                 i_ce;
   logic                 i_sync;
   logic [LGW-1:0]       i_lgsize;
   logic [2*WIDTH-1:0]   i_in;
   logic [2*WIDTH-1:0]   o_out;
   logic                 o_sync;
   logic                 o_valid;
   logic [LGW-1:0]       o_lgsize;
   logic                 o_err;

   modport master (
      output i_ce, i_sync, i_lgsize, i_in,
      input  o_out, o_sync, o_valid, o_lgsize, o_err
   );

   modport slave (
      input  i_ce, i_sync, i_lgsize, i_in,
      output o_out, o_sync, o_valid, o_lgsize, o_err
   );
endinterface

// File: rtl/fft_bitrev_var_pingpong_ram.sv
// Two-bank simple dual-port RAM; write and read share one enable, read is registered.
module fft_pingpong_ram #(
   parameter int AW = 9,
   parameter int DW = 52
) (
   input  logic          i_clk,
   input  logic          i_ce,
   input  logic          wbank,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW:0]   raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [0:(1 << (AW + 1)) - 1];

   // Block-RAM style port pair; contents are never reset.
   always_ff @(posedge i_clk) begin
      if (i_ce) begin
         mem[{wbank, waddr}] <= wdata;
         rdata               <= mem[raddr];
      end
   end
endmodule

// File: rtl/fft_bitrev_var.sv
// Runtime-size bit-reversal reorder: frames written in natural order to one bank
// while the previous frame is read bit-reversed from the other bank.
//
// state | meaning
// IDLE  | no frame framing yet; waiting for i_sync with a legal size
// FILL  | first frame after (re)sync being written; nothing valid to emit
// RUN   | steady stream; previous frame emitted while current one is written
module fft_bitrev_var
   import fft_pkg::*;
#(
   parameter int LGMAXSIZE = 9,
   parameter int WIDTH     = 26,
   parameter int LGMINSIZE = LGMINSIZE_DEF
) (
   input logic             i_clk,
   input logic             i_reset,
   fft_bitrev_var_if.slave bus
);
   localparam int LGW = $clog2(LGMAXSIZE + 1);
   localparam int AW  = LGMAXSIZE;

   state_t             state, state_nxt;
   logic [AW-1:0]      wcnt, wcnt_nxt, wcnt_inc, nmax, waddr;
   logic               bank, bank_nxt;
   logic [LGW-1:0]     cur_l, cur_l_nxt;
   logic [LGW-1:0]     bank_l [2];
   logic               lg_legal, wrap, misplaced, load_out;
   logic               sync_nxt, valid_nxt, err_nxt;
   logic [LGW-1:0]     lgsize_nxt;
   logic [AW:0]        raddr;
   logic [2*WIDTH-1:0] rdata;

   assign nmax      = AW'((32'd1 << cur_l) - 32'd1);
   assign wrap      = (wcnt == nmax);
   assign wcnt_inc  = wrap ? '0 : wcnt + AW'(1);
   assign lg_legal  = (bus.i_lgsize >= LGW'(LGMINSIZE)) && (bus.i_lgsize <= LGW'(LGMAXSIZE));
   assign misplaced = (wcnt != '0) || (bus.i_lgsize != cur_l);

   // The RAM read is registered, so fetch one element ahead: the element that
   // o_out must show on the next accepted sample.  On the wrap edge that is
   // element 0 of the frame just completed in the write bank.
   assign raddr = {wrap ? bank : ~bank, AW'(bitrev(BRW'(wcnt_inc), 5'(cur_l)))};

   fft_pingpong_ram #(.AW(AW), .DW(2*WIDTH)) u_ram (
      .i_clk (i_clk),
      .i_ce  (bus.i_ce),
      .wbank (bank),
      .waddr (waddr),
      .wdata (bus.i_in),
      .raddr (raddr),
      .rdata (rdata)
   );

   // Next-state, counter, bank and output decisions for an accepted sample.
   always_comb begin
      state_nxt  = state;
      wcnt_nxt   = wcnt_inc;
      bank_nxt   = bank ^ wrap;
      cur_l_nxt  = cur_l;
      waddr      = wcnt;
      load_out   = 1'b0;
      err_nxt    = 1'b0;
      sync_nxt   = 1'b0;
      valid_nxt  = 1'b0;
      lgsize_nxt = bus.o_lgsize;
      case (state)
         IDLE: begin
            wcnt_nxt = '0;
            bank_nxt = bank;
            if (bus.i_sync) begin
               if (lg_legal) begin
                  cur_l_nxt = bus.i_lgsize;
                  wcnt_nxt  = AW'(1);
                  state_nxt = FILL;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         FILL, RUN: begin
            if (bus.i_sync && misplaced) begin
               // Abandon the in-flight frame; this sample becomes sample 0.
               err_nxt  = 1'b1;
               bank_nxt = bank;
               waddr    = '0;
               if (lg_legal) begin
                  cur_l_nxt = bus.i_lgsize;
                  wcnt_nxt  = AW'(1);
                  state_nxt = FILL;
               end else begin
                  wcnt_nxt  = '0;
                  state_nxt = IDLE;
               end
            end else if (state == FILL) begin
               if (wrap) state_nxt = RUN;
            end else begin
               load_out   = 1'b1;
               valid_nxt  = 1'b1;
               sync_nxt   = (wcnt == '0);
               lgsize_nxt = bank_l[~bank];
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register; advances only on accepted samples.
   always_ff @(posedge i_clk) begin
      if (i_reset)        state <= IDLE;
      else if (bus.i_ce)  state <= state_nxt;
   end

   // Counters, latched sizes and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wcnt         <= '0;
         bank         <= 1'b0;
         cur_l        <= '0;
         bank_l[0]    <= '0;
         bank_l[1]    <= '0;
         bus.o_out    <= '0;
         bus.o_sync   <= 1'b0;
         bus.o_valid  <= 1'b0;
         bus.o_lgsize <= '0;
         bus.o_err    <= 1'b0;
      end else begin
         bus.o_err <= bus.i_ce & err_nxt;
         if (bus.i_ce) begin
            wcnt         <= wcnt_nxt;
            bank         <= bank_nxt;
            cur_l        <= cur_l_nxt;
            bank_l[bank] <= cur_l_nxt;
            bus.o_sync   <= sync_nxt;
            bus.o_valid  <= valid_nxt;
            bus.o_lgsize <= lgsize_nxt;
            if (load_out) bus.o_out <= rdata;
         end
      end
   end
endmodule

// File: tb/tb_fft_bitrev_var.sv
// Directed bench for the runtime-size bit-reversal reorder stage.
module tb_fft_bitrev_var;
   logic i_clk = 1'b0;
   logic i_reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 i_clk = ~i_clk;

   fft_bitrev_var_if #(.LGMAXSIZE(9), .WIDTH(26)) bus ();

   fft_bitrev_var #(.LGMAXSIZE(9), .WIDTH(26), .LGMINSIZE(2)) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int rv(input int k, input int l);
      int r = 0;
      for (int i = 0; i < l; i++)
         if ((k & (1 << i)) != 0) r |= 1 << (l - 1 - i);
      return r;
   endfunction

   function automatic logic [51:0] mk(input int k);
      return {26'(k), 26'(k + 5000)};
   endfunction

   task automatic cyc(input bit rst, input bit ce, input bit sy, input int lg, input logic [51:0] d);
      i_reset      = rst;
      bus.i_ce     = ce;
      bus.i_sync   = sy;
      bus.i_lgsize = 4'(lg);
      bus.i_in     = d;
      @(posedge i_clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_out"},    64'(bus.o_out),    64'd0);
      check({tag, "_valid"},  64'(bus.o_valid),  64'd0);
      check({tag, "_sync"},   64'(bus.o_sync),   64'd0);
      check({tag, "_lgsize"}, 64'(bus.o_lgsize), 64'd0);
      check({tag, "_err"},    64'(bus.o_err),    64'd0);
   endtask

   // Feed n samples base..base+n-1 at size l.  When chk is set, expect the
   // previous frame (pbase, size pl) to come out bit-reversed alongside.
   task automatic run_frame(input int base, input int l, input int n, input bit sy, input bit err0,
                            input bit chk, input int pbase, input int pl, input bit rnd);
      logic [51:0] prev_out;
      logic        prev_valid, prev_sync;
      logic [3:0]  prev_lg;
      for (int j = 0; j < n; j++) begin
         if (rnd && ($urandom_range(0, 1) == 1)) begin
            prev_out   = bus.o_out;
            prev_valid = bus.o_valid;
            prev_sync  = bus.o_sync;
            prev_lg    = bus.o_lgsize;
            cyc(1'b0, 1'b0, 1'b0, l, mk(9999));
            check("idle_out",    64'(bus.o_out),    64'(prev_out));
            check("idle_valid",  64'(bus.o_valid),  64'(prev_valid));
            check("idle_sync",   64'(bus.o_sync),   64'(prev_sync));
            check("idle_lgsize", 64'(bus.o_lgsize), 64'(prev_lg));
            check("idle_err",    64'(bus.o_err),    64'd0);
         end
         prev_out = bus.o_out;
         cyc(1'b0, 1'b1, sy && (j == 0), l, mk(base + j));
         check("err", 64'(bus.o_err), 64'(err0 && (j == 0)));
         if (chk) begin
            check("valid",  64'(bus.o_valid),  64'd1);
            check("out",    64'(bus.o_out),    64'(mk(pbase + rv(j, pl))));
            check("sync",   64'(bus.o_sync),   64'(j == 0));
            check("lgsize", 64'(bus.o_lgsize), 64'(pl));
         end else begin
            check("valid_lo", 64'(bus.o_valid), 64'd0);
            check("sync_lo",  64'(bus.o_sync),  64'd0);
            if (err0 && (j == 0)) check("resync_hold", 64'(bus.o_out), 64'(prev_out));
         end
      end
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 1'b0, 0, '0);
      cyc(1'b1, 1'b0, 1'b0, 0, '0);
      check_zero("reset");
      i_reset = 1'b0;
   endtask

   initial begin
      // 1: L=3 ramp, continuous enable
      do_reset();
      run_frame(0, 3, 8, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      run_frame(8, 3, 8, 1'b0, 1'b0, 1'b1, 0, 3, 1'b0);

      // 2: same with random gaps, then 3: size change at a frame boundary
      do_reset();
      run_frame(0, 3, 8, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
      run_frame(8, 3, 8, 1'b1, 1'b0, 1'b1, 0, 3, 1'b1);
      run_frame(16, 4, 16, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      run_frame(32, 4, 16, 1'b0, 1'b0, 1'b1, 16, 4, 1'b0);

      // 4: misplaced sync at wcnt=5
      do_reset();
      run_frame(0, 3, 8, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      run_frame(8, 3, 8, 1'b0, 1'b0, 1'b1, 0, 3, 1'b0);
      run_frame(16, 3, 5, 1'b0, 1'b0, 1'b1, 8, 3, 1'b0);
      run_frame(100, 3, 8, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      run_frame(200, 3, 8, 1'b0, 1'b0, 1'b1, 100, 3, 1'b0);

      // 5: largest size
      do_reset();
      run_frame(0, 9, 512, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      run_frame(512, 9, 512, 1'b0, 1'b0, 1'b1, 0, 9, 1'b0);

      // 6: reset mid-RUN, unsynced data ignored, then a fresh frame pair
      run_frame(1024, 9, 3, 1'b0, 1'b0, 1'b1, 512, 9, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 3, mk(7777));
      check_zero("mid_reset");
      run_frame(600, 3, 16, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
      run_frame(300, 3, 8, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      run_frame(400, 3, 8, 1'b0, 1'b0, 1'b1, 300, 3, 1'b0);

      // 5b: illegal sizes in IDLE raise o_err and leave the block idle
      do_reset();
      cyc(1'b0, 1'b1, 1'b1, 1, mk(1));
      check("ill1_err",   64'(bus.o_err),   64'd1);
      check("ill1_valid", 64'(bus.o_valid), 64'd0);
      cyc(1'b0, 1'b0, 1'b0, 1, mk(1));
      check("ill1_clear", 64'(bus.o_err),   64'd0);
      cyc(1'b0, 1'b1, 1'b1, 10, mk(2));
      check("ill10_err",   64'(bus.o_err),   64'd1);
      check("ill10_valid", 64'(bus.o_valid), 64'd0);
      run_frame(700, 3, 16, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
      run_frame(800, 2, 4, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      run_frame(900, 2, 4, 1'b0, 1'b0, 1'b1, 800, 2, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
